// File: rtl/ipv4_pkg.sv
// Shared definitions for the receive-side IPv4 controller: FSM encoding,
// drop reason codes, protocol/broadcast constants and header byte offsets.
package ipv4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DRAIN   = 2'd3
    } rx_state_e;

    localparam logic [2:0] DR_NONE    = 3'd0;
    localparam logic [2:0] DR_VER_IHL = 3'd1;
    localparam logic [2:0] DR_CSUM    = 3'd2;
    localparam logic [2:0] DR_DST     = 3'd3;
    localparam logic [2:0] DR_FRAG    = 3'd4;
    localparam logic [2:0] DR_PROTO   = 3'd5;
    localparam logic [2:0] DR_LEN     = 3'd6;
    localparam logic [2:0] DR_TRUNC   = 3'd7;

    localparam logic [7:0]  IP_PROTO_UDP = 8'h11;
    localparam logic [31:0] IPV4_BCAST   = 32'hFFFF_FFFF;
    localparam logic [15:0] CSUM_GOOD    = 16'hFFFF;

    localparam logic [5:0] OFF_TLEN_HI   = 6'd2;
    localparam logic [5:0] OFF_TLEN_LO   = 6'd3;
    localparam logic [5:0] OFF_FRAG_HI   = 6'd6;
    localparam logic [5:0] OFF_FRAG_LO   = 6'd7;
    localparam logic [5:0] OFF_PROTO     = 6'd9;
    localparam logic [5:0] OFF_SRC_FIRST = 6'd12;
    localparam logic [5:0] OFF_SRC_LAST  = 6'd15;
    localparam logic [5:0] OFF_DST_FIRST = 6'd16;
    localparam logic [5:0] OFF_DST_LAST  = 6'd19;

    // Header length in bytes from the 4-bit IHL field.
    function automatic logic [5:0] ihl_bytes(input logic [3:0] ihl);
        return {ihl, 2'b00};
    endfunction

endpackage

// File: rtl/ipv4_csum16.sv
// Byte-serial one's-complement accumulator over 16-bit words; sum_next_o
// already includes the byte presented this cycle.
module ipv4_csum16 #(
    parameter int OCT = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               clr_i,
    input  logic               valid_i,
    input  logic               odd_i,
    input  logic [OCT-1:0]     byte_i,
    output logic [2*OCT-1:0]   sum_next_o
);

    logic [2*OCT-1:0] sum_q, sum_d, base;
    logic [OCT-1:0]   hi_q, hi_d;
    logic [2*OCT:0]   wide;

    always_comb begin
        base  = clr_i ? '0 : sum_q;
        wide  = {1'b0, base} + {1'b0, hi_q, byte_i};
        sum_d = base;
        hi_d  = clr_i ? '0 : hi_q;
        if (valid_i) begin
            // The even byte is parked; the odd byte completes the word and
            // its carry out wraps back into bit 0.
            if (odd_i) begin
                sum_d = wide[2*OCT-1:0] + {{(2*OCT-1){1'b0}}, wide[2*OCT]};
            end else begin
                hi_d = byte_i;
            end
        end
    end

    assign sum_next_o = sum_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sum_q <= '0;
            hi_q  <= '0;
        end else begin
            sum_q <= sum_d;
            hi_q  <= hi_d;
        end
    end

endmodule

// File: rtl/rx_ipv4_ctrl.sv
// Receive IPv4 sequencing controller: validates the header byte by byte,
// forwards Total-Length-bounded payload and reports per-frame status.
module rx_ipv4_ctrl
    import ipv4_pkg::*;
#(
    parameter int         OCT          = 8,
    parameter logic [7:0] UDP          = IP_PROTO_UDP,
    parameter bit         ACCEPT_BCAST = 1'b1
) (
    input  logic           RX_CLK,
    input  logic           rst_n,
    input  logic [31:0]    ip_addr,
    input  logic           rx_valid,
    input  logic [OCT-1:0] rx_byte,
    output logic           payload_valid,
    output logic [OCT-1:0] payload_byte,
    output logic           payload_last,
    output logic           payload_abort,
    output logic           frame_ok,
    output logic           frame_drop,
    output logic [2:0]     drop_reason,
    output logic [31:0]    rx_src_ip,
    output logic [15:0]    payload_len,
    output logic [1:0]     state_dbg
);

    rx_state_e      state_q;
    logic           rx_valid_q;
    logic [5:0]     hdr_cnt_q;
    logic [5:0]     hdr_len_q;
    logic [15:0]    tlen_q;
    logic           mf_q;
    logic [12:0]    frag_off_q;
    logic [7:0]     proto_q;
    logic [31:0]    src_q;
    logic [31:0]    dst_q;
    logic [15:0]    remaining_q;

    logic           payload_valid_q;
    logic [OCT-1:0] payload_byte_q;
    logic           payload_last_q;
    logic           payload_abort_q;
    logic           frame_ok_q;
    logic           frame_drop_q;
    logic [2:0]     drop_reason_q;
    logic [31:0]    rx_src_ip_q;
    logic [15:0]    payload_len_q;

    logic           last_hdr;
    logic [31:0]    dst_now;
    logic [15:0]    plen_now;
    logic [15:0]    csum_next;
    logic [2:0]     verdict;

    ipv4_csum16 #(.OCT(OCT)) u_csum (
        .clk_i      (RX_CLK),
        .rst_n_i    (rst_n),
        .clr_i      (state_q == ST_IDLE),
        .valid_i    (rx_valid && (state_q == ST_IDLE || state_q == ST_HDR)),
        .odd_i      ((state_q == ST_HDR) && hdr_cnt_q[0]),
        .byte_i     (rx_byte),
        .sum_next_o (csum_next)
    );

    assign last_hdr = (state_q == ST_HDR) && (hdr_cnt_q == hdr_len_q - 6'd1);
    // With IHL=5 the last destination byte is still on the input wire.
    assign dst_now  = (hdr_cnt_q == OFF_DST_LAST) ? {dst_q[23:0], rx_byte} : dst_q;
    assign plen_now = tlen_q - {10'd0, hdr_len_q};

    always_comb begin
        verdict = DR_NONE;
        if (csum_next != CSUM_GOOD) begin
            verdict = DR_CSUM;
        end else if (!(dst_now == ip_addr || (ACCEPT_BCAST && dst_now == IPV4_BCAST))) begin
            verdict = DR_DST;
        end else if (mf_q || frag_off_q != 13'd0) begin
            verdict = DR_FRAG;
        end else if (proto_q != UDP) begin
            verdict = DR_PROTO;
        end else if (tlen_q < {10'd0, hdr_len_q}) begin
            verdict = DR_LEN;
        end
    end

    always_ff @(posedge RX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            // Treat the line as busy until it has been seen low once.
            rx_valid_q      <= 1'b1;
            hdr_cnt_q       <= '0;
            hdr_len_q       <= '0;
            tlen_q          <= '0;
            mf_q            <= 1'b0;
            frag_off_q      <= '0;
            proto_q         <= '0;
            src_q           <= '0;
            dst_q           <= '0;
            remaining_q     <= '0;
            payload_valid_q <= 1'b0;
            payload_byte_q  <= '0;
            payload_last_q  <= 1'b0;
            payload_abort_q <= 1'b0;
            frame_ok_q      <= 1'b0;
            frame_drop_q    <= 1'b0;
            drop_reason_q   <= DR_NONE;
            rx_src_ip_q     <= '0;
            payload_len_q   <= '0;
        end else begin
            rx_valid_q      <= rx_valid;
            payload_valid_q <= 1'b0;
            payload_last_q  <= 1'b0;
            payload_abort_q <= 1'b0;
            frame_ok_q      <= 1'b0;
            frame_drop_q    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (rx_valid_q) begin
                            state_q <= ST_DRAIN;
                        end else if (rx_byte[7:4] != 4'd4 || rx_byte[3:0] < 4'd5) begin
                            frame_drop_q  <= 1'b1;
                            drop_reason_q <= DR_VER_IHL;
                            state_q       <= ST_DRAIN;
                        end else begin
                            hdr_len_q <= ihl_bytes(rx_byte[3:0]);
                            hdr_cnt_q <= 6'd1;
                            state_q   <= ST_HDR;
                        end
                    end
                end

                ST_HDR: begin
                    if (!rx_valid) begin
                        frame_drop_q  <= 1'b1;
                        drop_reason_q <= DR_TRUNC;
                        state_q       <= ST_IDLE;
                    end else begin
                        hdr_cnt_q <= hdr_cnt_q + 6'd1;
                        case (hdr_cnt_q)
                            OFF_TLEN_HI: tlen_q[15:8] <= rx_byte;
                            OFF_TLEN_LO: tlen_q[7:0]  <= rx_byte;
                            OFF_FRAG_HI: begin
                                mf_q              <= rx_byte[5];
                                frag_off_q[12:8]  <= rx_byte[4:0];
                            end
                            OFF_FRAG_LO: frag_off_q[7:0] <= rx_byte;
                            OFF_PROTO:   proto_q         <= rx_byte;
                            default: ;
                        endcase
                        if (hdr_cnt_q >= OFF_SRC_FIRST && hdr_cnt_q <= OFF_SRC_LAST) begin
                            src_q <= {src_q[23:0], rx_byte};
                        end
                        if (hdr_cnt_q >= OFF_DST_FIRST && hdr_cnt_q <= OFF_DST_LAST) begin
                            dst_q <= {dst_q[23:0], rx_byte};
                        end
                        if (last_hdr) begin
                            if (verdict != DR_NONE) begin
                                frame_drop_q  <= 1'b1;
                                drop_reason_q <= verdict;
                                state_q       <= ST_DRAIN;
                            end else begin
                                rx_src_ip_q   <= src_q;
                                payload_len_q <= plen_now;
                                remaining_q   <= plen_now;
                                if (plen_now == 16'd0) begin
                                    frame_ok_q <= 1'b1;
                                    state_q    <= ST_DRAIN;
                                end else begin
                                    state_q    <= ST_PAYLOAD;
                                end
                            end
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (!rx_valid) begin
                        payload_abort_q <= 1'b1;
                        frame_drop_q    <= 1'b1;
                        drop_reason_q   <= DR_TRUNC;
                        state_q         <= ST_IDLE;
                    end else begin
                        payload_valid_q <= 1'b1;
                        payload_byte_q  <= rx_byte;
                        remaining_q     <= remaining_q - 16'd1;
                        // Bytes past Total Length are Ethernet padding.
                        if (remaining_q == 16'd1) begin
                            payload_last_q <= 1'b1;
                            frame_ok_q     <= 1'b1;
                            state_q        <= ST_DRAIN;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (!rx_valid) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign payload_valid = payload_valid_q;
    assign payload_byte  = payload_byte_q;
    assign payload_last  = payload_last_q;
    assign payload_abort = payload_abort_q;
    assign frame_ok      = frame_ok_q;
    assign frame_drop    = frame_drop_q;
    assign drop_reason   = drop_reason_q;
    assign rx_src_ip     = rx_src_ip_q;
    assign payload_len   = payload_len_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_rx_ipv4_ctrl.sv
// Randomised bench for rx_ipv4_ctrl: a frame-level model schedules the
// expected output events per clock edge and a compare process checks them.
module tb_rx_ipv4_ctrl;

    localparam logic [31:0] MY_IP    = 32'h0A00_0002;
    localparam logic [31:0] BCAST    = 32'hFFFF_FFFF;
    localparam bit          TB_BCAST = 1'b1;

    logic        RX_CLK;
    logic        rst_n;
    logic [31:0] ip_addr;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        payload_valid;
    logic [7:0]  payload_byte;
    logic        payload_last;
    logic        payload_abort;
    logic        frame_ok;
    logic        frame_drop;
    logic [2:0]  drop_reason;
    logic [31:0] rx_src_ip;
    logic [15:0] payload_len;
    logic [1:0]  state_dbg;

    rx_ipv4_ctrl #(.OCT(8), .UDP(8'h11), .ACCEPT_BCAST(TB_BCAST)) dut (
        .RX_CLK        (RX_CLK),
        .rst_n         (rst_n),
        .ip_addr       (ip_addr),
        .rx_valid      (rx_valid),
        .rx_byte       (rx_byte),
        .payload_valid (payload_valid),
        .payload_byte  (payload_byte),
        .payload_last  (payload_last),
        .payload_abort (payload_abort),
        .frame_ok      (frame_ok),
        .frame_drop    (frame_drop),
        .drop_reason   (drop_reason),
        .rx_src_ip     (rx_src_ip),
        .payload_len   (payload_len),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / edge counter ----------------
    initial RX_CLK = 1'b0;
    always #5 RX_CLK = ~RX_CLK;

    int edge_cnt = 0;
    always @(posedge RX_CLK) edge_cnt <= edge_cnt + 1;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        bit        pv;
        bit [7:0]  pb;
        bit        pl;
        bit        ok;
        bit        drop;
        bit        abort;
        bit [2:0]  reason;
        bit        acc;
        bit [31:0] src;
        bit [15:0] len;
    } ev_t;

    ev_t         ev[int];
    logic [7:0]  fb[$];
    logic [31:0] src_ip;
    int          n_checks = 0;
    int          n_err = 0;
    logic [2:0]  m_reason;
    logic [2:0]  h_reason = 0;
    logic [31:0] h_src = 0;
    logic [15:0] h_len = 0;
    int          pv_seen = 0, ok_seen = 0, drop_seen = 0, abort_seen = 0;
    logic [7:0]  last_pb = 0;
    ev_t         cur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [15:0] ocsum(input int hl);
        logic [31:0] t;
        t = 0;
        for (int i = 0; i < hl; i += 2) t += {16'd0, fb[i], fb[i+1]};
        while (t[31:16] != 0) t = {16'd0, t[15:0]} + {16'd0, t[31:16]};
        return t[15:0];
    endfunction

    task automatic touch(input int k);
        if (!ev.exists(k)) ev[k] = '0;
    endtask

    task automatic mark_drop(input int k, input logic [2:0] r);
        touch(k);
        ev[k].drop   = 1'b1;
        ev[k].reason = r;
        m_reason     = r;
    endtask

    // Byte k of the frame is sampled at edge s+k; rx_valid low at edge s+n.
    task automatic model_frame(input int s);
        int n, hl, tl, plen, e, idx;
        logic [31:0] dst, src;
        logic [15:0] fr;
        logic [2:0]  r;
        n = fb.size();
        m_reason = 3'd0;
        if (fb[0][7:4] != 4'd4 || fb[0][3:0] < 4'd5) begin
            mark_drop(s, 3'd1);
            return;
        end
        hl = int'(fb[0][3:0]) * 4;
        if (n < hl) begin
            mark_drop(s + n, 3'd7);
            return;
        end
        tl  = int'({fb[2], fb[3]});
        fr  = {fb[6], fb[7]};
        src = {fb[12], fb[13], fb[14], fb[15]};
        dst = {fb[16], fb[17], fb[18], fb[19]};
        e   = s + hl - 1;
        if (ocsum(hl) != 16'hFFFF)                          r = 3'd2;
        else if (!(dst == MY_IP || (TB_BCAST && dst == BCAST))) r = 3'd3;
        else if (fr[13] || fr[12:0] != 0)                   r = 3'd4;
        else if (fb[9] != 8'h11)                            r = 3'd5;
        else if (tl < hl)                                   r = 3'd6;
        else                                                r = 3'd0;
        if (r != 0) begin
            mark_drop(e, r);
            return;
        end
        plen = tl - hl;
        touch(e);
        ev[e].acc = 1'b1;
        ev[e].src = src;
        ev[e].len = plen[15:0];
        if (plen == 0) begin
            ev[e].ok = 1'b1;
            return;
        end
        for (int k = 0; k < plen; k++) begin
            idx = hl + k;
            if (idx >= n) begin
                mark_drop(s + n, 3'd7);
                ev[s + n].abort = 1'b1;
                return;
            end
            touch(s + idx);
            ev[s + idx].pv = 1'b1;
            ev[s + idx].pb = fb[idx];
            if (k == plen - 1) begin
                ev[s + idx].pl = 1'b1;
                ev[s + idx].ok = 1'b1;
            end
        end
    endtask

    task automatic purge(input int lim);
        int keys[$];
        foreach (ev[k]) if (k >= lim) keys.push_back(k);
        foreach (keys[i]) ev.delete(keys[i]);
    endtask

    // ---------------- compare process ----------------
    always @(negedge RX_CLK) begin
        if (ev.exists(edge_cnt)) cur = ev[edge_cnt];
        else cur = '0;
        if (!rst_n) begin
            h_reason = 0;
            h_src    = 0;
            h_len    = 0;
        end else begin
            if (cur.drop) h_reason = cur.reason;
            if (cur.acc) begin
                h_src = cur.src;
                h_len = cur.len;
            end
        end
        chk("ctl{pv,last,ok,drop,abort}",
            {59'd0, payload_valid, payload_last, frame_ok, frame_drop, payload_abort},
            {59'd0, cur.pv, cur.pl, cur.ok, cur.drop, cur.abort});
        if (cur.pv) chk("payload_byte", {56'd0, payload_byte}, {56'd0, cur.pb});
        chk("drop_reason", {61'd0, drop_reason}, {61'd0, h_reason});
        chk("src_len", {16'd0, rx_src_ip, payload_len}, {16'd0, h_src, h_len});
        if (payload_valid) pv_seen++;
        if (payload_last) last_pb = payload_byte;
        if (frame_ok) ok_seen++;
        if (frame_drop) drop_seen++;
        if (payload_abort) abort_seen++;
    end

    // ---------------- driver tasks ----------------
    task automatic build(input int ihl, input int tl, input int frag, input int proto,
                         input logic [31:0] dst, input int npay, input int npad,
                         input logic [7:0] seed);
        int hl;
        logic [15:0] ck;
        hl = ihl * 4;
        fb.delete();
        fb.push_back({4'd4, ihl[3:0]});
        fb.push_back(8'h00);
        fb.push_back(tl[15:8]);
        fb.push_back(tl[7:0]);
        fb.push_back(8'($urandom));
        fb.push_back(8'($urandom));
        fb.push_back(frag[15:8]);
        fb.push_back(frag[7:0]);
        fb.push_back(8'h40);
        fb.push_back(proto[7:0]);
        fb.push_back(8'h00);
        fb.push_back(8'h00);
        for (int i = 3; i >= 0; i--) fb.push_back(src_ip[8*i +: 8]);
        for (int i = 3; i >= 0; i--) fb.push_back(dst[8*i +: 8]);
        for (int i = 20; i < hl; i++) fb.push_back(8'($urandom));
        ck = ~ocsum(hl);
        fb[10] = ck[15:8];
        fb[11] = ck[7:0];
        for (int i = 0; i < npay; i++) fb.push_back(seed + 8'(i));
        for (int i = 0; i < npad; i++) fb.push_back(8'($urandom));
    endtask

    task automatic send(input int gap, input int rst_at);
        @(posedge RX_CLK); #1;
        model_frame(edge_cnt + 1);
        for (int k = 0; k < fb.size(); k++) begin
            if (rst_at >= 0 && k == rst_at) begin
                rst_n = 1'b0;
                purge(edge_cnt);
            end
            if (rst_at >= 0 && k == rst_at + 2) rst_n = 1'b1;
            if (rst_at >= 0 && k == rst_at + 5) chk("rst_join_drains", {62'd0, state_dbg}, 64'd3);
            rx_valid = 1'b1;
            rx_byte  = fb[k];
            @(posedge RX_CLK); #1;
        end
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
        repeat (gap) begin
            @(posedge RX_CLK); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    int pv0, ok0, dr0, ab0;

    task automatic snap();
        pv0 = pv_seen; ok0 = ok_seen; dr0 = drop_seen; ab0 = abort_seen;
    endtask

    initial begin
        rst_n    = 1'b0;
        ip_addr  = MY_IP;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        src_ip   = 32'hC0A8_0001;
        repeat (4) @(posedge RX_CLK);
        #1 rst_n = 1'b1;
        chk("reset_state", {62'd0, state_dbg}, 64'd0);
        chk("reset_outputs", {payload_valid, payload_last, payload_abort, frame_ok, frame_drop,
                              drop_reason, rx_src_ip, payload_len}, 64'd0);

        // Model pin: a known-good header sums to all-ones.
        fb = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
               8'hb8, 8'h61, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};
        chk("model_ref_csum", {48'd0, ocsum(20)}, 64'hFFFF);

        // Valid UDP frame, 8 payload bytes 01..08.
        build(5, 28, 0, 8'h11, MY_IP, 8, 0, 8'h01); snap(); send(3, -1);
        chk("t1_model_reason", {61'd0, m_reason}, 64'd0);
        chk("t1_pv_count", 64'(pv_seen - pv0), 64'd8);
        chk("t1_ok_count", 64'(ok_seen - ok0), 64'd1);
        chk("t1_last_byte", {56'd0, last_pb}, 64'h08);
        chk("t1_src", {32'd0, rx_src_ip}, 64'hC0A8_0001);
        chk("t1_len", {48'd0, payload_len}, 64'd8);

        // Corrupted checksum.
        build(5, 28, 0, 8'h11, MY_IP, 8, 0, 8'h01); fb[11] ^= 8'h5A; snap(); send(3, -1);
        chk("t2_model_reason", {61'd0, m_reason}, 64'd2);
        chk("t2_reason", {61'd0, drop_reason}, 64'd2);
        chk("t2_pv_count", 64'(pv_seen - pv0), 64'd0);
        chk("t2_drop_count", 64'(drop_seen - dr0), 64'd1);

        // 46-byte Ethernet-padded frame.
        build(5, 28, 0, 8'h11, MY_IP, 8, 18, 8'h10); snap(); send(3, -1);
        chk("t3_pv_count", 64'(pv_seen - pv0), 64'd8);
        chk("t3_ok_count", 64'(ok_seen - ok0), 64'd1);
        chk("t3_idle_after", {62'd0, state_dbg}, 64'd0);

        // IHL=6 with options.
        build(6, 32, 0, 8'h11, MY_IP, 8, 0, 8'h20); snap(); send(3, -1);
        chk("t4_pv_count", 64'(pv_seen - pv0), 64'd8);
        chk("t4_ok_count", 64'(ok_seen - ok0), 64'd1);

        build(5, 28, 16'h2000, 8'h11, MY_IP, 8, 0, 8'h01); send(3, -1);
        chk("t5_mf_reason", {61'd0, drop_reason}, 64'd4);
        build(5, 28, 0, 8'h06, MY_IP, 8, 0, 8'h01); send(3, -1);
        chk("t5_proto_reason", {61'd0, drop_reason}, 64'd5);
        build(5, 28, 0, 8'h11, BCAST, 8, 0, 8'h01); snap(); send(3, -1);
        chk("t5_bcast_ok", 64'(ok_seen - ok0), 64'd1);

        // Truncation after 3 payload bytes.
        build(5, 28, 0, 8'h11, MY_IP, 8, 0, 8'h01);
        while (fb.size() > 23) void'(fb.pop_back());
        snap(); send(3, -1);
        chk("t6_abort_count", 64'(abort_seen - ab0), 64'd1);
        chk("t6_pv_count", 64'(pv_seen - pv0), 64'd3);
        chk("t6_reason", {61'd0, drop_reason}, 64'd7);

        // Reset mid-payload with rx_valid held high, then a normal frame.
        build(5, 28, 0, 8'h11, MY_IP, 8, 10, 8'h01); send(3, 23);
        chk("t7_reason_cleared", {61'd0, drop_reason}, 64'd0);
        chk("t7_idle_after", {62'd0, state_dbg}, 64'd0);
        build(5, 28, 0, 8'h11, MY_IP, 8, 0, 8'h01); snap(); send(3, -1);
        chk("t7_next_ok", 64'(ok_seen - ok0), 64'd1);

        // Randomised frames.
        for (int f = 0; f < 160; f++) begin
            int ihl, npay, tl, frag, proto, kind, cut;
            logic [31:0] dst;
            ihl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 15)) : 5;
            npay  = $urandom_range(0, 24);
            tl    = ihl * 4 + npay;
            frag  = 0;
            proto = 8'h11;
            dst   = MY_IP;
            kind  = $urandom_range(0, 11);
            src_ip = $urandom;
            case (kind)
                1: dst   = BCAST;
                2: dst   = $urandom;
                3: frag  = 16'h2000;
                4: frag  = $urandom_range(1, 8191);
                5: frag  = 16'h4000;
                6: proto = 8'h06;
                7: tl    = $urandom_range(0, ihl * 4 - 1);
                default: ;
            endcase
            build(ihl, tl, frag, proto, dst, npay, $urandom_range(0, 12), 8'($urandom));
            if (kind == 8) fb[$urandom_range(0, ihl * 4 - 1)] ^= 8'($urandom_range(1, 255));
            if (kind == 9) fb[0] = 8'($urandom);
            if (kind == 10) begin
                cut = $urandom_range(1, fb.size());
                while (fb.size() > cut) void'(fb.pop_back());
            end
            send($urandom_range(1, 3), -1);
        end
        repeat (4) @(posedge RX_CLK);
        #1;
        chk("final_idle", {62'd0, state_dbg}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
